tlcd_diff_writer: RTL and testbench

TLCD_DIFF_WRITER -- requirements
Module: tlcd_diff_writer

---
 rtl/tlcd_diff_writer.sv | 190 +++++++++++++++++++
 tb/tb_tlcd_diff_writer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlcd_diff_writer.sv
// rtl/tlcd_diff_writer.sv - HD44780 16x2 frame writer: power-up init, then per-frame character writes
// Define TLCD_DIFF_EN to write only characters that differ from the on-display shadow copy.
module tlcd_diff_writer #(
  parameter int INIT_WAIT = 20000,
  parameter int CMD_WAIT  = 50,
  parameter int CLR_WAIT  = 2000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [127:0] FRAME_UPPER,
  input  logic [127:0] FRAME_LOWER,
  input  logic         FRAME_VALID,
  output logic         FRAME_READY,
  output logic         INIT_DONE,
  output logic         TLCD_E,
  output logic         TLCD_RS,
  output logic         TLCD_RW,
  output logic [7:0]   TLCD_DATA
);

  typedef enum logic [2:0] {PWRUP, INIT, IDLE, SCAN, WR_SETUP, WR_EHI, WR_WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt, r_wait;
  logic [1:0]  r_init_idx;
  logic        r_in_init, r_addr_phase, r_init_done;
  logic [5:0]  r_idx;
  logic [4:0]  r_prev_idx;
  logic        r_prev_valid;
  logic [7:0]  r_wr_data;
  logic        r_wr_rs;
  logic [7:0]  r_pending [32];
`ifdef TLCD_DIFF_EN
  logic [7:0]  r_shadow [32];
`endif

  logic       w_pwrup_done, w_wait_done, w_scan_end, w_differ, w_need_addr;
  logic [7:0] w_addr, w_init_cmd, w_cur;

  assign w_pwrup_done = (r_cnt == 32'(INIT_WAIT - 1));
  assign w_wait_done  = (r_cnt == r_wait - 32'd1);
  // Index 32 is a terminal scan slot so an unchanged frame still costs a fixed 33 cycles.
  assign w_scan_end   = r_idx[5];
  assign w_cur        = r_pending[r_idx[4:0]];
`ifdef TLCD_DIFF_EN
  assign w_differ     = (w_cur != r_shadow[r_idx[4:0]]);
`else
  assign w_differ     = 1'b1;
`endif
  // The cursor auto-increments, so a write right after index i-1 on the same line needs no address.
  assign w_need_addr  = !(r_prev_valid && (r_prev_idx == r_idx[4:0] - 5'd1) && (r_idx[3:0] != 4'd0));
  assign w_addr       = {(r_idx[4] ? 4'hC : 4'h8), r_idx[3:0]};

  always_comb begin
    case (r_init_idx)
      2'd0:    w_init_cmd = 8'h38;
      2'd1:    w_init_cmd = 8'h0C;
      2'd2:    w_init_cmd = 8'h06;
      default: w_init_cmd = 8'h01;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= PWRUP;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    TLCD_E      = 1'b0;
    TLCD_RS     = 1'b0;
    TLCD_RW     = 1'b0;
    TLCD_DATA   = 8'h00;
    FRAME_READY = 1'b0;
    INIT_DONE   = r_init_done;
    case (r_state)
      PWRUP:    if (w_pwrup_done) w_state_nxt = INIT;
      INIT:     w_state_nxt = WR_SETUP;
      IDLE: begin
        FRAME_READY = 1'b1;
        if (FRAME_VALID) w_state_nxt = SCAN;
      end
      SCAN: begin
        if (w_scan_end)    w_state_nxt = IDLE;
        else if (w_differ) w_state_nxt = WR_SETUP;
      end
      WR_SETUP: begin
        TLCD_RS     = r_wr_rs;
        TLCD_DATA   = r_wr_data;
        w_state_nxt = WR_EHI;
      end
      WR_EHI: begin
        TLCD_E      = 1'b1;
        TLCD_RS     = r_wr_rs;
        TLCD_DATA   = r_wr_data;
        w_state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        TLCD_RS   = r_wr_rs;
        TLCD_DATA = r_wr_data;
        if (w_wait_done) begin
          if (r_in_init)         w_state_nxt = (r_init_idx == 2'd3) ? IDLE : INIT;
          else if (r_addr_phase) w_state_nxt = WR_SETUP;
          else                   w_state_nxt = SCAN;
        end
      end
      default: w_state_nxt = PWRUP;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt        <= 32'd0;
      r_wait       <= 32'd0;
      r_init_idx   <= 2'd0;
      r_in_init    <= 1'b0;
      r_addr_phase <= 1'b0;
      r_init_done  <= 1'b0;
      r_idx        <= 6'd0;
      r_prev_idx   <= 5'd0;
      r_prev_valid <= 1'b0;
      r_wr_data    <= 8'h00;
      r_wr_rs      <= 1'b0;
      for (int k = 0; k < 32; k++) begin
        r_pending[k] <= 8'h00;
`ifdef TLCD_DIFF_EN
        r_shadow[k]  <= 8'h20;
`endif
      end
    end else begin
      case (r_state)
        PWRUP: r_cnt <= w_pwrup_done ? 32'd0 : r_cnt + 32'd1;
        INIT: begin
          r_wr_data <= w_init_cmd;
          r_wr_rs   <= 1'b0;
          r_wait    <= (r_init_idx == 2'd3) ? 32'(CLR_WAIT) : 32'(CMD_WAIT);
          r_in_init <= 1'b1;
        end
        IDLE: if (FRAME_VALID) begin
          for (int k = 0; k < 16; k++) begin
            r_pending[k]      <= FRAME_UPPER[127-8*k -: 8];
            r_pending[16 + k] <= FRAME_LOWER[127-8*k -: 8];
          end
          r_idx        <= 6'd0;
          r_prev_valid <= 1'b0;
        end
        SCAN: if (!w_scan_end) begin
          if (w_differ) begin
            r_wait       <= 32'(CMD_WAIT);
            r_addr_phase <= w_need_addr;
            r_wr_data    <= w_need_addr ? w_addr : w_cur;
            r_wr_rs      <= !w_need_addr;
          end else begin
            r_idx <= r_idx + 6'd1;
          end
        end
        WR_EHI: r_cnt <= 32'd0;
        WR_WAIT: begin
          if (!w_wait_done) begin
            r_cnt <= r_cnt + 32'd1;
          end else begin
            r_cnt <= 32'd0;
            if (r_in_init) begin
              if (r_init_idx == 2'd3) begin
                r_init_done <= 1'b1;
                r_in_init   <= 1'b0;
                r_init_idx  <= 2'd0;
              end else begin
                r_init_idx <= r_init_idx + 2'd1;
              end
            end else if (r_addr_phase) begin
              r_addr_phase <= 1'b0;
              r_wr_data    <= w_cur;
              r_wr_rs      <= 1'b1;
            end else begin
`ifdef TLCD_DIFF_EN
              r_shadow[r_idx[4:0]] <= w_cur;
`endif
              r_prev_idx   <= r_idx[4:0];
              r_prev_valid <= 1'b1;
              r_idx        <= r_idx + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlcd_diff_writer.sv
// tb/tb_tlcd_diff_writer.sv - directed self-checking bench for tlcd_diff_writer
`timescale 1ns/1ps
module tb_tlcd_diff_writer;

  localparam int INIT_WAIT = 10;
  localparam int CMD_WAIT  = 3;
  localparam int CLR_WAIT  = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [127:0] FRAME_UPPER = '0;
  logic [127:0] FRAME_LOWER = '0;
  logic         FRAME_VALID = 1'b0;
  logic         FRAME_READY, INIT_DONE, TLCD_E, TLCD_RS, TLCD_RW;
  logic [7:0]   TLCD_DATA;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] q[$];
  logic [8:0] exp_init [4] = '{9'h038, 9'h00C, 9'h006, 9'h001};
  logic [127:0] full_up, full_lo;

  tlcd_diff_writer #(.INIT_WAIT(INIT_WAIT), .CMD_WAIT(CMD_WAIT), .CLR_WAIT(CLR_WAIT)) dut (
    .CLK(CLK), .RST(RST),
    .FRAME_UPPER(FRAME_UPPER), .FRAME_LOWER(FRAME_LOWER),
    .FRAME_VALID(FRAME_VALID), .FRAME_READY(FRAME_READY), .INIT_DONE(INIT_DONE),
    .TLCD_E(TLCD_E), .TLCD_RS(TLCD_RS), .TLCD_RW(TLCD_RW), .TLCD_DATA(TLCD_DATA)
  );

  always #500 CLK = ~CLK;

  // Each E pulse is one cycle wide, so one negedge sample per bus write.
  always @(negedge CLK) begin
    if (TLCD_E === 1'b1) begin
      q.push_back({TLCD_RS, TLCD_DATA});
      n_tests++;
      if (TLCD_RW !== 1'b0) begin
        n_fail++;
        $display("FAIL rw_low: RW=%b required 0", TLCD_RW);
      end
    end
  end

  task automatic send_frame(input logic [127:0] up, input logic [127:0] lo, output bit ok);
    int c;
    c = 0;
    while (FRAME_READY !== 1'b1 && c < 3000) begin
      @(negedge CLK);
      c++;
    end
    ok = (FRAME_READY === 1'b1);
    if (ok) begin
      FRAME_UPPER = up;
      FRAME_LOWER = lo;
      FRAME_VALID = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      FRAME_VALID = 1'b0;
      FRAME_UPPER = ~up;
      FRAME_LOWER = ~lo;
    end
  endtask

  task automatic wait_ready(inout int cyc);
    while (FRAME_READY !== 1'b1 && cyc < 3000) begin
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_tests++;
    if ({TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA} !== 11'h000) begin
      n_fail++;
      $display("FAIL reset_bus: E/RS/RW/DATA=%h required 000", {TLCD_E, TLCD_RS, TLCD_RW, TLCD_DATA});
    end
    n_tests++;
    if ({FRAME_READY, INIT_DONE} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: READY/INIT_DONE=%b required 00", {FRAME_READY, INIT_DONE});
    end
  endtask

  task automatic test_init(input string tag);
    q.delete();
    RST = 1'b0;
    repeat (38) @(posedge CLK);
    @(negedge CLK);
    n_tests++;
    if (INIT_DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_early: INIT_DONE=%b required 0 at cycle 38", tag, INIT_DONE);
    end
    @(posedge CLK);
    @(negedge CLK);
    n_tests++;
    if ({INIT_DONE, FRAME_READY} !== 2'b11) begin
      n_fail++;
      $display("FAIL %s_done: INIT_DONE/READY=%b required 11 at cycle 39", tag, {INIT_DONE, FRAME_READY});
    end
    n_tests++;
    if (q.size() != 4) begin
      n_fail++;
      $display("FAIL %s_count: pulses=%0d required 4", tag, q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (q[i] !== exp_init[i]) begin
          n_fail++;
          $display("FAIL %s_cmd%0d: rs/data=%h required %h", tag, i, q[i], exp_init[i]);
        end
      end
    end
  endtask

`ifdef TLCD_DIFF_EN
  task automatic test_diff;
    logic [127:0] up, lo;
    logic [8:0] exp3 [3] = '{9'h083, 9'h141, 9'h142};
    logic [8:0] exp4 [4] = '{9'h0C0, 9'h100, 9'h0CF, 9'h104};
    bit ok;
    int cyc;
    up = {16{8'h20}};
    lo = {16{8'h20}};
    q.delete();
    send_frame(up, lo, ok);
    cyc = 0;
    wait_ready(cyc);
    n_tests++;
    if (!ok || cyc != 33 || q.size() != 0) begin
      n_fail++;
      $display("FAIL diff_same: ok=%0d cycles=%0d pulses=%0d required 1/33/0", ok, cyc, q.size());
    end
    up[127-8*3 -: 8] = 8'h41;
    up[127-8*4 -: 8] = 8'h42;
    q.delete();
    send_frame(up, lo, ok);
    cyc = 0;
    wait_ready(cyc);
    n_tests++;
    if (q.size() != 3) begin
      n_fail++;
      $display("FAIL diff_adj_count: pulses=%0d required 3", q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (q[i] !== exp3[i]) begin
          n_fail++;
          $display("FAIL diff_adj%0d: rs/data=%h required %h", i, q[i], exp3[i]);
        end
      end
    end
    lo[127 -: 8] = 8'h00;
    lo[7:0]      = 8'h04;
    q.delete();
    send_frame(up, lo, ok);
    cyc = 0;
    wait_ready(cyc);
    n_tests++;
    if (q.size() != 4) begin
      n_fail++;
      $display("FAIL diff_glyph_count: pulses=%0d required 4", q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (q[i] !== exp4[i]) begin
          n_fail++;
          $display("FAIL diff_glyph%0d: rs/data=%h required %h", i, q[i], exp4[i]);
        end
      end
    end
  endtask
`endif

  task automatic test_full_frame;
    logic [8:0] exp [34];
    bit ok;
    int cyc;
    for (int k = 0; k < 16; k++) begin
      full_up[127-8*k -: 8] = 8'h41 + 8'(k);
      full_lo[127-8*k -: 8] = (k < 8) ? 8'(7 - k) : 8'h30 + 8'(k);
    end
    exp[0]  = 9'h080;
    exp[17] = 9'h0C0;
    for (int k = 0; k < 16; k++) begin
      exp[1 + k]  = {1'b1, full_up[127-8*k -: 8]};
      exp[18 + k] = {1'b1, full_lo[127-8*k -: 8]};
    end
    q.delete();
    send_frame(full_up, full_lo, ok);
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      FRAME_VALID = 1'b1;
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
      n_tests++;
      if (FRAME_READY !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_ready: READY=%b required 0", FRAME_READY);
      end
    end
    FRAME_VALID = 1'b0;
    wait_ready(cyc);
    n_tests++;
    if (!ok || cyc != 203) begin
      n_fail++;
      $display("FAIL full_latency: ok=%0d cycles=%0d required 1/203", ok, cyc);
    end
    n_tests++;
    if (q.size() != 34) begin
      n_fail++;
      $display("FAIL full_count: pulses=%0d required 34", q.size());
    end else begin
      for (int i = 0; i < 34; i++) begin
        n_tests++;
        if (q[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL full_write%0d: rs/data=%h required %h", i, q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_repeat_frame;
    bit ok;
    int cyc;
    int exp_pulses, exp_cyc;
`ifdef TLCD_DIFF_EN
    exp_pulses = 0;
    exp_cyc    = 33;
`else
    exp_pulses = 34;
    exp_cyc    = 203;
`endif
    q.delete();
    send_frame(full_up, full_lo, ok);
    cyc = 0;
    wait_ready(cyc);
    n_tests++;
    if (!ok || q.size() != exp_pulses || cyc != exp_cyc) begin
      n_fail++;
      $display("FAIL repeat_frame: ok=%0d pulses=%0d cycles=%0d required 1/%0d/%0d",
               ok, q.size(), cyc, exp_pulses, exp_cyc);
    end
  endtask

  task automatic test_reset_mid_write;
    logic [127:0] up;
    bit ok;
    int c;
    for (int k = 0; k < 16; k++) up[127-8*k -: 8] = 8'h61 + 8'(k);
    send_frame(up, full_lo, ok);
    c = 0;
    while (!(TLCD_E === 1'b1 && TLCD_RS === 1'b1) && c < 500) begin
      @(negedge CLK);
      c++;
    end
    n_tests++;
    if (!ok || c >= 500) begin
      n_fail++;
      $display("FAIL midwrite_found: ok=%0d waited=%0d required data E pulse", ok, c);
    end
    RST = 1'b1;
    #1;
    n_tests++;
    if ({TLCD_E, FRAME_READY, INIT_DONE} !== 3'b000) begin
      n_fail++;
      $display("FAIL midwrite_abort: E/READY/INIT_DONE=%b required 000", {TLCD_E, FRAME_READY, INIT_DONE});
    end
    @(negedge CLK);
    test_init("reinit");
  endtask

  initial begin
    test_reset();
    test_init("init");
`ifdef TLCD_DIFF_EN
    test_diff();
`endif
    test_full_frame();
    test_repeat_frame();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
